id_ex_stage: RTL and testbench

//  ID/EX pipeline register and hazard control for the MIPS pipeline; the producer side of the EX-stage input interface.

---
 rtl/id_ex_stage_pkg.sv | 56 +++++
 rtl/id_ex_stage_if.sv | 42 ++++
 rtl/id_ex_stage_forward_sel.sv | 24 ++
 rtl/id_ex_stage.sv | 90 +++++++++
 tb/tb_id_ex_stage.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register: control packing,
// forwarding-select encodings and ALU op codes.
package id_ex_stage_pkg;

  localparam int INST_SZ  = 32;
  localparam int ALU_OP   = 3;
  localparam int FORW_ALU = 2;
  localparam int REG_SZ   = 5;
  localparam int CTRL_SZ  = ALU_OP + 7;

  localparam logic [REG_SZ-1:0] REG_RA = REG_SZ'(31);

  // Bit positions inside the packed control word, MSB first.
  localparam int CTRL_ALU_SRC    = ALU_OP + 6;
  localparam int CTRL_REG_DST    = ALU_OP + 5;
  localparam int CTRL_JAL_SEL    = ALU_OP + 4;
  localparam int CTRL_ALU_OP_LSB = 4;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;

  typedef enum logic [FORW_ALU-1:0] {
    FW_NONE = 2'b00,
    FW_MEM  = 2'b01,
    FW_WB   = 2'b10
  } fw_sel_t;

  typedef enum logic [ALU_OP-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic              alu_src;
    logic              reg_dst;
    logic              jal_sel;
    logic [ALU_OP-1:0] alu_op;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
  } ctrl_t;

  function automatic logic [REG_SZ-1:0] ex_dest(input ctrl_t c,
                                                input logic [REG_SZ-1:0] rt,
                                                input logic [REG_SZ-1:0] rd);
    if (c.jal_sel)      return REG_RA;
    else if (c.reg_dst) return rd;
    else                return rt;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between decode, the ID/EX register and EX: decoded operands in, registered
// operands, control and forwarding selects out, plus hazard side-band signals.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic                 halt;
  logic                 flush;
  logic [INST_SZ-1:0]   read_data_1_d;
  logic [INST_SZ-1:0]   read_data_2_d;
  logic [INST_SZ-1:0]   instr_imm_d;
  logic [REG_SZ-1:0]    instr_rs_d;
  logic [REG_SZ-1:0]    instr_rt_d;
  logic [REG_SZ-1:0]    instr_rd_d;
  ctrl_t                ctrl_d;
  logic                 reg_write_m;
  logic [REG_SZ-1:0]    write_reg_m;

  logic                 stall_hu;
  logic [INST_SZ-1:0]   read_data_1_e;
  logic [INST_SZ-1:0]   read_data_2_e;
  logic [INST_SZ-1:0]   instr_imm_e;
  logic [REG_SZ-1:0]    instr_rt_e;
  logic [REG_SZ-1:0]    instr_rd_e;
  ctrl_t                ctrl_e;
  fw_sel_t              forward_a_fu;
  fw_sel_t              forward_b_fu;
  logic [REG_SZ-1:0]    write_reg_e;

  modport master (
    input  halt, flush, read_data_1_d, read_data_2_d, instr_imm_d,
           instr_rs_d, instr_rt_d, instr_rd_d, ctrl_d, reg_write_m, write_reg_m,
    output stall_hu, read_data_1_e, read_data_2_e, instr_imm_e, instr_rt_e,
           instr_rd_e, ctrl_e, forward_a_fu, forward_b_fu, write_reg_e
  );

  modport slave (
    output halt, flush, read_data_1_d, read_data_2_d, instr_imm_d,
           instr_rs_d, instr_rt_d, instr_rd_d, ctrl_d, reg_write_m, write_reg_m,
    input  stall_hu, read_data_1_e, read_data_2_e, instr_imm_e, instr_rt_e,
           instr_rd_e, ctrl_e, forward_a_fu, forward_b_fu, write_reg_e
  );
endinterface

// File: rtl/id_ex_stage_forward_sel.sv
// Forwarding select for one source register: the instruction now in EX is the
// newest producer and beats MEM; register 0 is hard-wired and never forwarded.
module id_ex_stage_forward_sel
  import id_ex_stage_pkg::*;
(
  input  logic [REG_SZ-1:0] src,
  input  logic              ex_we,
  input  logic [REG_SZ-1:0] ex_dst,
  input  logic              m_we,
  input  logic [REG_SZ-1:0] m_dst,
  output fw_sel_t           sel
);

  always_comb begin
    sel = FW_NONE;
    if (src != '0) begin
      if (ex_we && (ex_dst == src))
        sel = FW_MEM;
      else if (m_we && (m_dst == src))
        sel = FW_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and halt handling; forward
// selects are resolved here one cycle early so EX sees them registered.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.master bus
);

  ctrl_t              ctrl_q;
  logic [INST_SZ-1:0] read_data_1_q;
  logic [INST_SZ-1:0] read_data_2_q;
  logic [INST_SZ-1:0] instr_imm_q;
  logic [REG_SZ-1:0]  instr_rt_q;
  logic [REG_SZ-1:0]  instr_rd_q;
  fw_sel_t            forward_a_q;
  fw_sel_t            forward_b_q;
  fw_sel_t            forward_a_next;
  fw_sel_t            forward_b_next;
  logic [REG_SZ-1:0]  write_reg;
  logic               load_use;
  logic               bubble;

  assign write_reg = ex_dest(ctrl_q, instr_rt_q, instr_rd_q);

  // A load in EX whose result ID needs cannot be forwarded in time.
  assign load_use = ctrl_q.mem_read && (write_reg != '0) &&
                    ((write_reg == bus.instr_rs_d) || (write_reg == bus.instr_rt_d));
  assign bubble   = bus.flush || load_use;
  assign bus.stall_hu = !reset && (bus.halt || (load_use && !bus.flush));

  id_ex_stage_forward_sel u_forward_a (
    .src    (bus.instr_rs_d),
    .ex_we  (ctrl_q.reg_write),
    .ex_dst (write_reg),
    .m_we   (bus.reg_write_m),
    .m_dst  (bus.write_reg_m),
    .sel    (forward_a_next)
  );

  id_ex_stage_forward_sel u_forward_b (
    .src    (bus.instr_rt_d),
    .ex_we  (ctrl_q.reg_write),
    .ex_dst (write_reg),
    .m_we   (bus.reg_write_m),
    .m_dst  (bus.write_reg_m),
    .sel    (forward_b_next)
  );

  // Data fields load even under a bubble; zeroed control makes them inert.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= '0;
      read_data_1_q <= '0;
      read_data_2_q <= '0;
      instr_imm_q   <= '0;
      instr_rt_q    <= '0;
      instr_rd_q    <= '0;
      forward_a_q   <= FW_NONE;
      forward_b_q   <= FW_NONE;
    end else if (!bus.halt) begin
      read_data_1_q <= bus.read_data_1_d;
      read_data_2_q <= bus.read_data_2_d;
      instr_imm_q   <= bus.instr_imm_d;
      instr_rt_q    <= bus.instr_rt_d;
      instr_rd_q    <= bus.instr_rd_d;
      if (bubble) begin
        ctrl_q      <= '0;
        forward_a_q <= FW_NONE;
        forward_b_q <= FW_NONE;
      end else begin
        ctrl_q      <= bus.ctrl_d;
        forward_a_q <= forward_a_next;
        forward_b_q <= forward_b_next;
      end
    end
  end

  assign bus.ctrl_e        = ctrl_q;
  assign bus.read_data_1_e = read_data_1_q;
  assign bus.read_data_2_e = read_data_2_q;
  assign bus.instr_imm_e   = instr_imm_q;
  assign bus.instr_rt_e    = instr_rt_q;
  assign bus.instr_rd_e    = instr_rd_q;
  assign bus.forward_a_fu  = forward_a_q;
  assign bus.forward_b_fu  = forward_b_q;
  assign bus.write_reg_e   = write_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven bench for id_ex_stage: each row gives ID-side stimulus and the
// expected stall/selects; the expected EX state is queued and checked after the edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef enum {K_LOAD, K_BUBBLE, K_HOLD, K_RESET} kind_t;

  typedef struct {
    logic        rst;
    logic        halt;
    logic        flush;
    ctrl_t       ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic        m_we;
    logic [4:0]  m_dst;
    kind_t       kind;
    logic        exp_stall;
    fw_sel_t     exp_fa, exp_fb;
  } vec_t;

  typedef struct {
    ctrl_t       ctrl;
    logic [31:0] d1, d2, imm;
    logic [4:0]  rt, rd, wr;
    fw_sel_t     fa, fb;
    bit          chk_data;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  id_ex_stage_if bus();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  vec_t  vecs[$];
  exp_t  exp_q[$];
  exp_t  last_exp;
  int    checks = 0;
  int    passes = 0;
  ctrl_t c_addu, c_subu, c_lw, c_jal;

  function automatic ctrl_t mk_ctrl(input logic alu_src, input logic reg_dst,
                                    input logic jal, input logic [2:0] op,
                                    input logic mem_read, input logic mem_write,
                                    input logic reg_write, input logic mem_to_reg);
    logic [CTRL_SZ-1:0] b;
    b = '0;
    b[CTRL_ALU_SRC]   = alu_src;
    b[CTRL_REG_DST]   = reg_dst;
    b[CTRL_JAL_SEL]   = jal;
    b[CTRL_ALU_OP_LSB +: ALU_OP] = op;
    b[CTRL_MEM_READ]  = mem_read;
    b[CTRL_MEM_WRITE] = mem_write;
    b[CTRL_REG_WRITE] = reg_write;
    b[CTRL_MEM_TO_REG] = mem_to_reg;
    return ctrl_t'(b);
  endfunction

  task automatic add(input logic rst, input logic halt, input logic flush,
                     input ctrl_t c, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                     input logic [31:0] imm, input logic m_we, input logic [4:0] m_dst,
                     input kind_t kind, input logic st, input fw_sel_t fa, input fw_sel_t fb);
    vec_t v;
    v.rst = rst; v.halt = halt; v.flush = flush; v.ctrl = c;
    v.rs = rs; v.rt = rt; v.rd = rd; v.d1 = d1; v.d2 = d2; v.imm = imm;
    v.m_we = m_we; v.m_dst = m_dst; v.kind = kind;
    v.exp_stall = st; v.exp_fa = fa; v.exp_fb = fb;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL row %0d %s: got 0x%0h, expected 0x%0h", idx, name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    exp_t e;
    reset             = v.rst;
    bus.halt          = v.halt;
    bus.flush         = v.flush;
    bus.ctrl_d        = v.ctrl;
    bus.instr_rs_d    = v.rs;
    bus.instr_rt_d    = v.rt;
    bus.instr_rd_d    = v.rd;
    bus.read_data_1_d = v.d1;
    bus.read_data_2_d = v.d2;
    bus.instr_imm_d   = v.imm;
    bus.reg_write_m   = v.m_we;
    bus.write_reg_m   = v.m_dst;
    #1;
    check("stall", idx, 32'(bus.stall_hu), 32'(v.exp_stall));
    e = last_exp;
    case (v.kind)
      K_RESET: begin
        e.ctrl = '0; e.d1 = '0; e.d2 = '0; e.imm = '0;
        e.rt = '0; e.rd = '0; e.wr = '0;
        e.fa = FW_NONE; e.fb = FW_NONE; e.chk_data = 1'b1;
      end
      K_BUBBLE: begin
        e.ctrl = '0; e.fa = FW_NONE; e.fb = FW_NONE; e.chk_data = 1'b0;
      end
      K_LOAD: begin
        e.ctrl = v.ctrl; e.d1 = v.d1; e.d2 = v.d2; e.imm = v.imm;
        e.rt = v.rt; e.rd = v.rd;
        e.wr = v.ctrl.jal_sel ? 5'd31 : (v.ctrl.reg_dst ? v.rd : v.rt);
        e.fa = v.exp_fa; e.fb = v.exp_fb; e.chk_data = 1'b1;
      end
      default: ;
    endcase
    e.idx = idx;
    last_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic check_output();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    check("ctrl_e", e.idx, 32'(bus.ctrl_e), 32'(e.ctrl));
    check("forward_a", e.idx, 32'(bus.forward_a_fu), 32'(e.fa));
    check("forward_b", e.idx, 32'(bus.forward_b_fu), 32'(e.fb));
    if (e.chk_data) begin
      check("read_data_1_e", e.idx, bus.read_data_1_e, e.d1);
      check("read_data_2_e", e.idx, bus.read_data_2_e, e.d2);
      check("instr_imm_e", e.idx, bus.instr_imm_e, e.imm);
      check("instr_rt_e", e.idx, 32'(bus.instr_rt_e), 32'(e.rt));
      check("instr_rd_e", e.idx, 32'(bus.instr_rd_e), 32'(e.rd));
      check("write_reg_e", e.idx, 32'(bus.write_reg_e), 32'(e.wr));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    c_addu = mk_ctrl(0, 1, 0, ALU_ADD, 0, 0, 1, 0);
    c_subu = mk_ctrl(0, 1, 0, ALU_SUB, 0, 0, 1, 0);
    c_lw   = mk_ctrl(1, 0, 0, ALU_ADD, 1, 0, 1, 1);
    c_jal  = mk_ctrl(0, 0, 1, ALU_ADD, 0, 0, 1, 0);
    last_exp = '{ctrl: '0, d1: '0, d2: '0, imm: '0, rt: '0, rd: '0, wr: '0,
                 fa: FW_NONE, fb: FW_NONE, chk_data: 1'b0, idx: 0};

    // rst halt flush ctrl rs rt rd d1 d2 imm m_we m_dst kind stall fa fb
    add(1, 0, 0, c_addu,  3,  4,  5, $urandom, $urandom, $urandom, 1, 3, K_RESET, 0, FW_NONE, FW_NONE);
    add(1, 0, 0, c_lw,    3,  3,  0, $urandom, $urandom, $urandom, 0, 0, K_RESET, 0, FW_NONE, FW_NONE);
    add(0, 0, 0, c_addu,  3,  4,  5, 32'h10, 32'h20, 32'h0, 0, 0, K_LOAD, 0, FW_NONE, FW_NONE);
    add(0, 0, 0, c_subu,  5,  6,  7, 32'h55, 32'h66, 32'h0, 0, 0, K_LOAD, 0, FW_MEM,  FW_NONE);
    add(0, 0, 0, c_lw,    7,  8,  0, 32'h70, 32'h80, 32'h4, 1, 7, K_LOAD, 0, FW_MEM,  FW_NONE);
    add(0, 0, 0, c_addu,  8,  9, 10, 32'h81, 32'h91, 32'h0, 1, 7, K_BUBBLE, 1, FW_NONE, FW_NONE);
    add(0, 0, 0, c_addu,  8,  9, 10, 32'h81, 32'h91, 32'h0, 1, 8, K_LOAD, 0, FW_WB,   FW_NONE);
    add(0, 0, 0, c_lw,    0, 12,  0, 32'h0,  32'hc0, 32'h8, 0, 0, K_LOAD, 0, FW_NONE, FW_NONE);
    add(0, 0, 1, c_addu, 12, 12, 13, 32'hc1, 32'hc2, 32'h0, 0, 0, K_BUBBLE, 0, FW_NONE, FW_NONE);
    add(0, 0, 0, c_addu,  2,  3, 14, 32'h22, 32'h33, 32'h0, 0, 0, K_LOAD, 0, FW_NONE, FW_NONE);
    add(0, 1, 0, c_lw,   14, 14,  0, 32'hde, 32'had, 32'h1, 1, 14, K_HOLD, 1, FW_NONE, FW_NONE);
    add(0, 1, 1, c_subu,  1,  2,  3, 32'hbe, 32'hef, 32'h2, 0, 0, K_HOLD, 1, FW_NONE, FW_NONE);
    add(0, 1, 0, c_jal,   0,  0,  0, 32'h12, 32'h34, 32'h3, 1, 2, K_HOLD, 1, FW_NONE, FW_NONE);
    add(0, 0, 0, c_addu, 14, 14, 15, 32'h44, 32'h45, 32'h0, 0, 0, K_LOAD, 0, FW_MEM,  FW_MEM);
    add(0, 0, 0, c_lw,    0, 16,  0, 32'h0,  32'h16, 32'h10, 0, 0, K_LOAD, 0, FW_NONE, FW_NONE);
    add(0, 1, 0, c_addu, 16,  0, 17, 32'h61, 32'h0,  32'h0, 0, 0, K_HOLD, 1, FW_NONE, FW_NONE);
    add(0, 0, 0, c_addu, 16,  0, 17, 32'h61, 32'h0,  32'h0, 0, 0, K_BUBBLE, 1, FW_NONE, FW_NONE);
    add(0, 0, 0, c_addu, 16,  0, 17, 32'h61, 32'h0,  32'h0, 1, 16, K_LOAD, 0, FW_WB,  FW_NONE);
    add(0, 0, 0, c_lw,    0, 20,  0, 32'h0,  32'h20, 32'h14, 0, 0, K_LOAD, 0, FW_NONE, FW_NONE);
    add(1, 0, 0, c_addu, 20,  1, 21, 32'h71, 32'h72, 32'h0, 0, 0, K_RESET, 0, FW_NONE, FW_NONE);
    add(0, 0, 0, c_lw,    0,  0,  0, 32'h0,  32'h0,  32'h18, 0, 0, K_LOAD, 0, FW_NONE, FW_NONE);
    add(0, 0, 0, c_addu,  0,  0,  0, 32'h1,  32'h2,  32'h0, 1, 0, K_LOAD, 0, FW_NONE, FW_NONE);
    add(0, 0, 0, c_addu,  0,  5,  6, 32'h3,  32'h4,  32'h0, 1, 5, K_LOAD, 0, FW_NONE, FW_WB);
    add(0, 0, 0, c_jal,   0,  0,  0, 32'h0,  32'h0,  32'h40, 0, 0, K_LOAD, 0, FW_NONE, FW_NONE);
    add(0, 0, 0, c_addu, 31,  6,  1, 32'h5,  32'h6,  32'h0, 1, 6, K_LOAD, 0, FW_MEM,  FW_WB);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i], i);
      @(posedge clk);
      #1;
      check_output();
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
